osd_glyph_reader: RTL and testbench
===================================

// Module: osd_glyph_reader
// PURPOSE
//  Reads ascii_char_rom on behalf of the OSD overlay.
//  - Accepts {char code, glyph row} requests and generates the ROM address.
//  - Captures the returned row bitmap after the ROM read latency.
//  - Serialises the bitmap into a 1-bit/cycle pixel stream with valid/ready backpressure.
//  - A one-row prefetch buffer lets consecutive glyphs stream without gaps.
// PARAMETERS
//  ADDR_WIDTH  11  ROM address width = 7-bit char code + 4-bit row.
//  DATA_WIDTH  9   ROM word width. Bit 8 is unused padding.
//  GLYPH_W     8   Pixels per glyph row, taken from rom_rd_data[GLYPH_W-1:0]. Must be <= DATA_WIDTH.
//  RD_LATENCY  1   ROM clocks from address edge to data (1 = no output reg, 2 = output reg). Legal values: 1..2.
//  MSB_FIRST   1   1: bit GLYPH_W-1 is the leftmost pixel, shifted out first. 0: bit 0 first.
//  SUB_CHAR    7'h3F  Substituted code for req_char >= 8'h80 ('?').
// PORTS
//  clk          in   1   System clock, also drives ascii_char_rom.
//  rst          in   1   Synchronous, active-high reset.
//  req_valid    in   1   Glyph-row request valid.
//  req_ready    out  1   Request accepted when req_valid & req_ready at a clk edge.
//  req_char     in   8   ASCII code.
//  req_row      in   4   Glyph row, 0..15.
//  rom_addr     out  11  To ascii_char_rom addr. Registered.
//  rom_rd_data  in   9   From ascii_char_rom rd_data.
//  pix_valid    out  1   Pixel valid.
//  pix_ready    in   1   Consumer ready.
//  pix_data     out  1   1 = foreground pixel.
//  pix_last     out  1   High with the last pixel (GLYPH_W-th) of a row.
//  busy         out  1   Fetch outstanding, buffer full, or shifter non-empty.
// BEHAVIOUR
//  Reset values: rom_addr 0, pix_valid 0, pix_data 0, pix_last 0, busy 0.
//  - req_ready is forced 0 while rst=1.
//  - Reset mid-operation discards any in-flight ROM data, buffer and shifter contents.
//  - No stale pixel appears after release.
//  Request handshake:
//  - Address formed on accept: rom_addr <= {code, req_row}, where code = req_char[7] ? SUB_CHAR : req_char[6:0].
//  - At most one fetch is outstanding.
//  - req_ready = !rst & !fetch_pending & !buf_full.
//  Fetch pipeline:
//  - valid shift register of depth RD_LATENCY tracks the fetch.
//  - Accept at edge N: rom_rd_data is sampled at edge N+RD_LATENCY+1.
//  - If the shifter is empty, or its last pixel is consumed at that same edge, the data loads straight into the shifter.
//  - Otherwise the data goes into the 1-entry buffer.
//  - Buffer-to-shifter transfer happens on the edge the last pixel is consumed, giving zero bubble cycles.
//  Shifter:
//  - States: EMPTY (pix_valid=0) and SHIFT (pix_valid=1, pixel count 0..GLYPH_W-1).
//  - pix_data = current bit; pix_last = (count == GLYPH_W-1).
//  - Advances only on pix_valid & pix_ready.
//  - Last pixel consumed with no new data available -> EMPTY.
//  - pix_data and pix_last are held stable while pix_valid & !pix_ready.
//  Simultaneous events:
//  - Accept, ROM capture and last-pixel consume may all occur on the same edge.
//  - Ordering: the shifter loads the captured row, or the buffer if it is full (buffer is older).
//  - Captured data then goes to the buffer if the buffer was just emptied.
//  - No data is lost or duplicated.
//  Latency:
//  - Idle block, accept at edge N -> pix_valid first high after edge N+RD_LATENCY+1.
//  - Sustained throughput is 1 pixel/clk when requests are presented on time (GLYPH_W >= RD_LATENCY+2).
// TESTING
//  1. ROM model word @0x413 = 9'h118; req 'A'(8'h41), row 3, pix_ready=1
//     -> rom_addr=11'h413; pixels 0,0,0,1,1,0,0,0; pix_last on 8th; first pix_valid 2 clks after accept.
//  2. 4 back-to-back requests, pix_ready=1
//     -> exactly 32 consecutive pix_valid cycles, no gap; pix_last every 8th.
//  3. pix_ready = 0 for 5 clks mid-row
//     -> pix_data/pix_last stable; req_ready drops once buffer and fetch are full; no pixel lost.
//  4. req_char=8'h85, row 2 -> rom_addr = {7'h3F, 4'h2} = 11'h3F2.
//  5. rst pulsed 1 clk during pixel 4 of a row with a fetch pending
//     -> all outputs 0 next clk; after release no pixels until a new request.
//  6. RD_LATENCY=2 with registered ROM model: rerun 1-3
//     -> identical pixel streams; first-pixel latency is 3 clks.

Source files
------------

// File: rtl/osd_glyph_reader.sv
// Fetches glyph rows from ascii_char_rom and serialises them as a 1-bit pixel stream.
// Latency RD_LATENCY+1 clocks from accept to first pixel; pix_ready low stalls the shifter, then the buffer, then req_ready.
module osd_glyph_reader #(
  parameter int           ADDR_WIDTH = 11,
  parameter int           DATA_WIDTH = 9,
  parameter int           GLYPH_W    = 8,
  parameter int           RD_LATENCY = 1,
  parameter bit           MSB_FIRST  = 1'b1,
  parameter logic [6:0]   SUB_CHAR   = 7'h3F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_char,
  input  logic [3:0]            req_row,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_data,
  output logic                  pix_last,
  output logic                  busy
);

  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t               state, state_nxt;
  logic [RD_LATENCY:0]  pipe;
  logic [GLYPH_W-1:0]   sh_bits, bits_nxt;
  logic [GLYPH_W-1:0]   buf_bits, buf_nxt;
  logic                 buf_full, buf_full_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [GLYPH_W-1:0]   cap_row;
  logic [6:0]           code;
  logic                 fetch_pending, capture, accept, take, last_take, free;
  logic                 unused_pad;

  // The capture stage counts as pending so a new fetch can never land on a full buffer.
  assign fetch_pending = |pipe;
  assign capture       = pipe[RD_LATENCY];
  assign req_ready     = !rst && !fetch_pending && !buf_full;
  assign accept        = req_valid && req_ready;
  assign code          = req_char[7] ? SUB_CHAR : req_char[6:0];
  assign cap_row       = rom_rd_data[GLYPH_W-1:0];
  assign unused_pad    = ^rom_rd_data;

  assign pix_valid = (state == SHIFT);
  assign pix_data  = pix_valid && (MSB_FIRST ? sh_bits[GLYPH_W-1] : sh_bits[0]);
  assign pix_last  = pix_valid && (cnt == CW'(GLYPH_W-1));
  assign take      = pix_valid && pix_ready;
  assign last_take = take && pix_last;
  assign free      = (state == EMPTY) || last_take;
  assign busy      = fetch_pending || buf_full || pix_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe     <= '0;
      rom_addr <= '0;
    end else begin
      pipe <= (RD_LATENCY + 1)'({pipe, accept});
      if (accept) rom_addr <= ADDR_WIDTH'({code, req_row});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      sh_bits  <= '0;
      cnt      <= '0;
      buf_bits <= '0;
      buf_full <= 1'b0;
    end else begin
      state    <= state_nxt;
      sh_bits  <= bits_nxt;
      cnt      <= cnt_nxt;
      buf_bits <= buf_nxt;
      buf_full <= buf_full_nxt;
    end
  end

  // The buffered row is older than a row captured on the same edge, so it reaches the shifter first.
  always_comb begin
    state_nxt    = state;
    bits_nxt     = sh_bits;
    cnt_nxt      = cnt;
    buf_nxt      = buf_bits;
    buf_full_nxt = buf_full;
    if (free) begin
      cnt_nxt = '0;
      if (buf_full) begin
        state_nxt    = SHIFT;
        bits_nxt     = buf_bits;
        buf_full_nxt = capture;
        if (capture) buf_nxt = cap_row;
      end else if (capture) begin
        state_nxt = SHIFT;
        bits_nxt  = cap_row;
      end else begin
        state_nxt = EMPTY;
      end
    end else begin
      if (take) begin
        cnt_nxt  = cnt + 1'b1;
        bits_nxt = MSB_FIRST ? {sh_bits[GLYPH_W-2:0], 1'b0} : {1'b0, sh_bits[GLYPH_W-1:1]};
      end
      if (capture) begin
        buf_nxt      = cap_row;
        buf_full_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osd_glyph_reader.sv
// Bench for osd_glyph_reader: one instance per ROM latency, driven in turn against a row-level pixel model.
module tb_osd_glyph_reader;

  logic        clk = 1'b0;
  logic        rst_a       [2];
  logic        req_valid_a [2];
  logic        req_ready_a [2];
  logic [7:0]  req_char_a  [2];
  logic [3:0]  req_row_a   [2];
  logic [10:0] rom_addr_a  [2];
  logic        pix_valid_a [2];
  logic        pix_ready_a [2];
  logic        pix_data_a  [2];
  logic        pix_last_a  [2];
  logic        busy_a      [2];
  logic [8:0]  rom_q0, rom_q1a, rom_q1b;

  int total = 0;
  int bad   = 0;
  int d;
  logic [1:0]  exp_q [$];
  logic [10:0] exp_addr;
  logic        addr_pend, acc, seen;
  int          vld_cnt, gaps, lasts;
  logic [7:0]  obs;

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_fn(input logic [10:0] a);
    if (a == 11'h413) return 9'h118;
    return {a[0], a[7:0] ^ {a[10:4], a[3]} ^ 8'h5A};
  endfunction

  always_ff @(posedge clk) begin
    rom_q0  <= rom_fn(rom_addr_a[0]);
    rom_q1a <= rom_fn(rom_addr_a[1]);
    rom_q1b <= rom_q1a;
  end

  osd_glyph_reader #(.RD_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst_a[0]), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_char(req_char_a[0]), .req_row(req_row_a[0]), .rom_addr(rom_addr_a[0]),
    .rom_rd_data(rom_q0), .pix_valid(pix_valid_a[0]), .pix_ready(pix_ready_a[0]),
    .pix_data(pix_data_a[0]), .pix_last(pix_last_a[0]), .busy(busy_a[0]));

  osd_glyph_reader #(.RD_LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst_a[1]), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_char(req_char_a[1]), .req_row(req_row_a[1]), .rom_addr(rom_addr_a[1]),
    .rom_rd_data(rom_q1b), .pix_valid(pix_valid_a[1]), .pix_ready(pix_ready_a[1]),
    .pix_data(pix_data_a[1]), .pix_last(pix_last_a[1]), .busy(busy_a[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s (lat%0d): got=%0h want=%0h at %0t", tag, d + 1, got, want, $time);
    end
  endtask

  // A row request expands to GLYPH_W pixels, leftmost (bit 7) first, last flag on the eighth.
  task automatic push_row(input logic [7:0] c, input logic [3:0] r);
    logic [6:0] code;
    logic [8:0] w;
    code = (c >= 8'h80) ? 7'h3F : c[6:0];
    w = rom_fn({code, r});
    exp_addr = {code, r};
    for (int i = 0; i < 8; i++) exp_q.push_back({w[7 - i], i == 7});
  endtask

  // Inputs are set at a negedge; everything observed here holds until the coming posedge.
  task automatic tick();
    logic [1:0] e;
    #1;
    acc = 1'b0;
    if (rst_a[d]) begin
      exp_q.delete();
      addr_pend = 1'b0;
    end else begin
      if (addr_pend) begin
        check("rom_addr", rom_addr_a[d], exp_addr);
        addr_pend = 1'b0;
      end
      if (pix_valid_a[d]) begin
        vld_cnt++;
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("pix_valid_unexpected", pix_valid_a[d], 0);
        end else begin
          e = exp_q[0];
          check("pix_data", pix_data_a[d], e[1]);
          check("pix_last", pix_last_a[d], e[0]);
          if (pix_ready_a[d]) begin
            void'(exp_q.pop_front());
            obs = {obs[6:0], pix_data_a[d]};
            if (pix_last_a[d]) lasts++;
          end
        end
      end else if (seen && exp_q.size() != 0) begin
        gaps++;
      end
      if (req_valid_a[d] && req_ready_a[d]) begin
        acc = 1'b1;
        push_row(req_char_a[d], req_row_a[d]);
        addr_pend = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_stats();
    vld_cnt = 0; gaps = 0; lasts = 0; seen = 1'b0; obs = 8'h00;
  endtask

  task automatic new_req();
    req_char_a[d] = 8'($urandom);
    req_row_a[d]  = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid_a[d] = 1'b0;
    pix_ready_a[d] = 1'b1;
    while ((busy_a[d] || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_bounded", n < 300, 1);
    check("drain_left", exp_q.size(), 0);
    check("drain_busy", busy_a[d], 0);
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!pix_valid_a[d] && g < 20) begin
      tick();
      if (acc) new_req();
      g++;
    end
    check("pix_valid_timeout", pix_valid_a[d], 1);
  endtask

  task automatic run_suite();
    int k, g;
    logic sd, sl;
    exp_q.delete();
    addr_pend = 1'b0;
    clr_stats();
    req_valid_a[d] = 1'b0;
    pix_ready_a[d] = 1'b0;
    rst_a[d] = 1'b1;
    tick();
    tick();
    check("rst_rom_addr", rom_addr_a[d], 0);
    check("rst_pix_valid", pix_valid_a[d], 0);
    check("rst_pix_data", pix_data_a[d], 0);
    check("rst_pix_last", pix_last_a[d], 0);
    check("rst_busy", busy_a[d], 0);
    check("rst_req_ready", req_ready_a[d], 0);
    rst_a[d] = 1'b0;
    tick();
    check("idle_req_ready", req_ready_a[d], 1);

    // 'A' row 3: known bitmap and first-pixel latency
    clr_stats();
    pix_ready_a[d] = 1'b1;
    req_valid_a[d] = 1'b1;
    req_char_a[d] = 8'h41;
    req_row_a[d] = 4'd3;
    tick();
    check("a_accept", acc, 1);
    req_valid_a[d] = 1'b0;
    check("a_rom_addr", rom_addr_a[d], 11'h413);
    k = 0;
    while (!pix_valid_a[d] && k < 10) begin
      tick();
      k++;
    end
    check("first_pix_latency", k, d + 2);
    drain();
    check("a_bitmap", obs, 8'h18);
    check("a_lasts", lasts, 1);

    // back-to-back rows stream without a bubble
    clr_stats();
    k = 0;
    g = 0;
    new_req();
    while (k < 4 && g < 200) begin
      req_valid_a[d] = 1'b1;
      tick();
      if (acc) begin
        k++;
        new_req();
      end
      g++;
    end
    drain();
    check("b2b_valid_cycles", vld_cnt, 32);
    check("b2b_gaps", gaps, 0);
    check("b2b_lasts", lasts, 4);

    // mid-row stall holds the pixel and eventually closes req_ready
    clr_stats();
    new_req();
    req_valid_a[d] = 1'b1;
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc) new_req();
    end
    pix_ready_a[d] = 1'b0;
    sd = pix_data_a[d];
    sl = pix_last_a[d];
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", pix_valid_a[d], 1);
      check("stall_data", pix_data_a[d], sd);
      check("stall_last", pix_last_a[d], sl);
    end
    check("stall_req_ready", req_ready_a[d], 0);
    drain();

    // codes >= 0x80 fetch the substitute glyph
    req_valid_a[d] = 1'b1;
    req_char_a[d] = 8'h85;
    req_row_a[d] = 4'd2;
    tick();
    req_valid_a[d] = 1'b0;
    check("sub_rom_addr", rom_addr_a[d], 11'h3F2);
    drain();

    // reset mid-row with a fetch in flight
    new_req();
    req_valid_a[d] = 1'b1;
    g = 0;
    while (!acc && g < 20) begin
      tick();
      g++;
    end
    req_valid_a[d] = 1'b0;
    wait_valid();
    for (int i = 0; i < 3; i++) tick();
    new_req();
    req_valid_a[d] = 1'b1;
    tick();
    check("rst_mid_accept", acc, 1);
    req_valid_a[d] = 1'b0;
    check("rst_mid_busy", busy_a[d], 1);
    rst_a[d] = 1'b1;
    tick();
    check("rstmid_pix_valid", pix_valid_a[d], 0);
    check("rstmid_pix_data", pix_data_a[d], 0);
    check("rstmid_pix_last", pix_last_a[d], 0);
    check("rstmid_rom_addr", rom_addr_a[d], 0);
    check("rstmid_busy", busy_a[d], 0);
    check("rstmid_req_ready", req_ready_a[d], 0);
    rst_a[d] = 1'b0;
    clr_stats();
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_pixels", vld_cnt, 0);
    check("post_rst_busy", busy_a[d], 0);

    // randomized traffic
    clr_stats();
    new_req();
    for (int i = 0; i < 1500; i++) begin
      req_valid_a[d] = ($urandom_range(0, 3) != 0);
      pix_ready_a[d] = (i % 200 > 190) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
      if (acc) new_req();
    end
    drain();
    check("rand_rows_seen", lasts > 20, 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1;
      req_valid_a[i] = 1'b0;
      req_char_a[i] = 8'h00;
      req_row_a[i] = 4'h0;
      pix_ready_a[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      d = i;
      run_suite();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
